alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), rst_n input 1 (async active-low reset).
REQ-002 Requester ports (k = 0,1) SHALL be:
- reqk_valid input 1
- reqk_ready output 1
- reqk_a input 32
- reqk_b input 32
- reqk_op input 3 (ALU opcode)
- reqk_unsig input 1
REQ-003 ALU-side ports SHALL be:
- alu_a output 32
- alu_b output 32
- alu_op output 3
- alu_unsig output 1
- alu_out input 32
- alu_ovf input 1 (combinational ALU results)
REQ-004 Response ports SHALL be:
- rsp_valid output 1
- rsp_ready input 1
- rsp_id output 1 (granted requester)
- rsp_data output 32
- rsp_ovf output 1
- rsp_err output 1
REQ-005 The block SHALL have busy output 1, high whenever state is not IDLE.

Function
REQ-006 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-007 IDLE: when any reqk_valid is high, the block SHALL grant exactly one requester, assert its reqk_ready combinationally in that cycle, latch a/b/op/unsig and the grant id, and move to EXEC.
REQ-008 reqk_ready SHALL be high only in IDLE and only for the granted requester; a transfer occurs when valid and ready are both high.
REQ-009 EXEC: alu_a/alu_b/alu_op/alu_unsig SHALL drive the latched operands. At the clock edge ending EXEC, the block SHALL capture alu_out and alu_ovf and move to RESP.
REQ-010 In IDLE and RESP, the ALU-side outputs SHALL hold the last latched operands (zero after reset).
REQ-011 RESP: rsp_valid SHALL be high, with rsp_id/rsp_data/rsp_ovf/rsp_err stable until rsp_ready is sampled high. The FSM then returns to IDLE.
REQ-012 Latency SHALL be: accept at edge N, rsp_valid high from cycle N+2; maximum throughput is one operation per 3 cycles.
REQ-013 rsp_ovf SHALL be the captured alu_ovf ANDed with NOT the latched unsig.
REQ-014 Opcodes 3'b011 and 3'b111 SHALL be illegal. For them, rsp_err=1, rsp_data=0 and rsp_ovf=0; the request still passes through EXEC and RESP with normal latency.
REQ-015 For legal opcodes, rsp_err SHALL be 0.
REQ-016 A requester dropping valid before it is granted SHALL NOT be granted; no request queuing is performed.
REQ-017 Requests arriving while busy SHALL see ready low and SHALL be arbitrated on the next IDLE cycle.
REQ-018 An rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-019 On rst_n low, the FSM SHALL go to IDLE asynchronously, abandoning any in-flight operation; no response is produced for it.
REQ-020 On rst_n low, all outputs SHALL reset to 0, including rsp_valid, both ready signals, busy, the ALU-side outputs and the response fields.
REQ-021 On rst_n low, the round-robin pointer SHALL reset to favour requester 0.
REQ-022 Reset release SHALL be synchronous to clk; the first grant can occur in the first cycle after release.

Configuration
REQ-023 With macro ALU_ARB_ROUND_ROBIN_EN defined, simultaneous valid requests SHALL be granted to the requester not granted most recently. The pointer SHALL update only on a grant.
REQ-024 Without ALU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests, and the pointer logic SHALL be absent.
REQ-025 A single request SHALL be granted identically in both configurations.

Verification
REQ-026 Single add: req0 a=0x00000005, b=0x00000003, op=010 accepted at edge N -> rsp_valid at N+2, rsp_data=0x00000008, rsp_id=0, rsp_ovf=0, rsp_err=0.
REQ-027 Signed overflow: req1 a=0x7FFFFFFF, b=1, op=010, unsig=0 -> rsp_data=0x80000000, rsp_ovf=1; the same request with unsig=1 -> rsp_ovf=0.
REQ-028 Contention: both valid continuously, four operations -> with the macro, rsp_id sequence 0,1,0,1; without it, 0,0,0,0.
REQ-029 Backpressure and illegal op: req0 op=011 with rsp_ready held low for 5 cycles -> rsp_valid, rsp_err=1 and rsp_data=0 stay stable, both ready signals stay low, and the response completes on the first rsp_ready cycle.
REQ-030 Reset mid-operation: rst_n low during EXEC -> rsp_valid, busy and ALU-side outputs are 0 immediately; after release, a new req1 subtract a=10, b=3, op=110 returns 7 with rsp_id=1.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// An IDLE/EXEC/RESP FSM grants one request, drives the latched operands to
// the ALU for one cycle, captures the result and holds it until accepted.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req{0,1}_valid/ready  request handshake; a, b, op, unsig operands
//   alu_a/b/op/unsig      operands to the ALU; alu_out, alu_ovf results
//   rsp_valid/ready       response handshake; rsp_id, rsp_data, rsp_ovf,
//                         rsp_err response fields
//   busy                  high whenever the FSM is not in IDLE
// Config: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration;
//   otherwise requester 0 has fixed priority.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_op,
   input  logic        req0_unsig,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_op,
   input  logic        req1_unsig,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   output logic        alu_unsig,
   input  logic [31:0] alu_out,
   input  logic        alu_ovf,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        rsp_ovf,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [2:0]  op_q, op_d;
   logic        unsig_q, unsig_d;
   logic        id_q, id_d;
   logic [31:0] data_q, data_d;
   logic        ovf_q, ovf_d;
   logic        err_q, err_d;

   logic any_valid;
   logic gnt_id;
   logic grant;
   logic illegal;

   assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   // prio_q names the requester that wins a tie; it flips away from
   // whoever was just granted, so a tie goes to the other side.
   logic prio_q, prio_d;

   always_comb begin
      gnt_id = ~req0_valid;
      if (req0_valid && req1_valid) begin
         gnt_id = prio_q;
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (grant) begin
         prio_d = ~gnt_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end
`else
   // Requester 0 wins whenever it is valid.
   always_comb begin
      gnt_id = ~req0_valid;
   end
`endif

   assign grant = (state_q == IDLE) && any_valid;

   assign req0_ready = grant && !gnt_id;
   assign req1_ready = grant && gnt_id;

   // Opcodes x11 are reserved.
   assign illegal = (op_q[1:0] == 2'b11);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      unsig_d = unsig_q;
      id_d    = id_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               id_d    = gnt_id;
               a_d     = gnt_id ? req1_a     : req0_a;
               b_d     = gnt_id ? req1_b     : req0_b;
               op_d    = gnt_id ? req1_op    : req0_op;
               unsig_d = gnt_id ? req1_unsig : req0_unsig;
               state_d = EXEC;
            end
         end
         EXEC: begin
            err_d   = illegal;
            data_d  = illegal ? 32'd0 : alu_out;
            // Overflow only has meaning for signed arithmetic.
            ovf_d   = !illegal && alu_ovf && !unsig_q;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= 3'd0;
         unsig_q <= 1'b0;
         id_q    <= 1'b0;
         data_q  <= 32'd0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         unsig_q <= unsig_d;
         id_q    <= id_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign alu_unsig = unsig_q;

   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign rsp_ovf   = ovf_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != IDLE);

endmodule
